// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported, registered-output memory.
// One access is in flight at a time; read data is returned only to the port that asked for it.
module mem_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0_VALID,
  input  logic             REQ0_RW,
  input  logic [WIDTH-1:0] REQ0_ADDR,
  input  logic [31:0]      REQ0_DIN,
  input  logic             REQ1_VALID,
  input  logic             REQ1_RW,
  input  logic [WIDTH-1:0] REQ1_ADDR,
  input  logic [31:0]      REQ1_DIN,
  output logic             REQ0_READY,
  output logic             REQ1_READY,
  output logic             RSP0_VALID,
  output logic             RSP1_VALID,
  output logic [31:0]      RSP0_DATA,
  output logic [31:0]      RSP1_DATA,
  output logic             MEM_VALID,
  output logic             MEM_RW,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic [31:0]      MEM_DIN,
  input  logic [31:0]      MEM_DOUT,
  output logic             BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;  // 1 = port 1 holds the most recent grant
  logic             gnt_q, gnt_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [31:0]      rsp0_data_q, rsp0_data_d;
  logic [31:0]      rsp1_data_q, rsp1_data_d;
  logic             sel1;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    din_d        = din_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    sel1         = 1'b0;
    REQ0_READY   = 1'b0;
    REQ1_READY   = 1'b0;
    MEM_VALID    = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ0_VALID || REQ1_VALID) begin
          // On a tie the port that did not win last time takes the grant.
          sel1       = REQ1_VALID && (!REQ0_VALID || !last_q);
          REQ0_READY = !sel1;
          REQ1_READY = sel1;
          gnt_d      = sel1;
          last_d     = sel1;
          rw_d       = sel1 ? REQ1_RW   : REQ0_RW;
          addr_d     = sel1 ? REQ1_ADDR : REQ0_ADDR;
          din_d      = sel1 ? REQ1_DIN  : REQ0_DIN;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        MEM_VALID = 1'b1;
        state_d   = rw_q ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        // Memory output is valid now; the response pulse appears next cycle.
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = MEM_DOUT;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = MEM_DOUT;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign MEM_RW     = rw_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_DIN    = din_q;
  assign RSP0_VALID = rsp0_valid_q;
  assign RSP1_VALID = rsp1_valid_q;
  assign RSP0_DATA  = rsp0_data_q;
  assign RSP1_DATA  = rsp1_data_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of request vectors with expected grants, a registered
// memory model, and a scoreboard that predicts every memory strobe and read response.
module tb_mem_arbiter;
  localparam int W = 8;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          REQ0_VALID, REQ0_RW, REQ1_VALID, REQ1_RW;
  logic [W-1:0]  REQ0_ADDR, REQ1_ADDR;
  logic [31:0]   REQ0_DIN, REQ1_DIN;
  logic          REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID;
  logic [31:0]   RSP0_DATA, RSP1_DATA;
  logic          MEM_VALID, MEM_RW, BUSY;
  logic [W-1:0]  MEM_ADDR;
  logic [31:0]   MEM_DIN;
  logic [31:0]   MEM_DOUT;

  mem_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_RW(REQ0_RW), .REQ0_ADDR(REQ0_ADDR), .REQ0_DIN(REQ0_DIN),
    .REQ1_VALID(REQ1_VALID), .REQ1_RW(REQ1_RW), .REQ1_ADDR(REQ1_ADDR), .REQ1_DIN(REQ1_DIN),
    .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
    .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
    .RSP0_DATA(RSP0_DATA), .RSP1_DATA(RSP1_DATA),
    .MEM_VALID(MEM_VALID), .MEM_RW(MEM_RW), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [W-1:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  // Memory model: unwritten words read back as pat(addr); read data one cycle after the strobe.
  bit [31:0] mem [256];
  bit        mem_seen [256];
  bit [31:0] mem_dout;
  always @(posedge CLK) begin
    if (MEM_VALID) begin
      if (MEM_RW) begin
        mem[MEM_ADDR]      <= MEM_DIN;
        mem_seen[MEM_ADDR] <= 1'b1;
      end else begin
        mem_dout <= mem_seen[MEM_ADDR] ? mem[MEM_ADDR] : pat(MEM_ADDR);
      end
    end
  end
  assign MEM_DOUT = mem_dout;

  typedef struct {
    logic v0; logic rw0; logic [W-1:0] a0; logic [31:0] d0;
    logic v1; logic rw1; logic [W-1:0] a1; logic [31:0] d1;
    logic gnt;
  } req_t;
  typedef struct { logic rw; logic [W-1:0] addr; logic [31:0] din; int cyc; } mop_t;
  typedef struct { logic port; logic [31:0] data; int cyc; } rsp_t;

  mop_t      mq[$];
  rsp_t      rq[$];
  bit [31:0] ref_mem [256];
  bit        ref_seen [256];
  logic [31:0] exp_rsp0 = 32'h0, exp_rsp1 = 32'h0;
  logic      prev_mv = 1'b0;
  int        checks = 0, failures = 0;
  req_t      vec [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'h0, act}, {31'h0, exp});
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic monitor();
    mop_t m; rsp_t r; logic p; logic rw; logic [W-1:0] a; logic [31:0] d;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        mq.delete(); rq.delete();
        exp_rsp0 = 32'h0; exp_rsp1 = 32'h0; prev_mv = 1'b0;
        continue;
      end
      if (MEM_VALID) begin
        chkb("mem_valid_back_to_back", prev_mv, 1'b0);
        chkb("busy_during_issue", BUSY, 1'b1);
        if (mq.size() == 0) flag("unexpected_mem_valid");
        else begin
          m = mq.pop_front();
          chkb("mem_rw", MEM_RW, m.rw);
          chk("mem_addr", 32'(MEM_ADDR), 32'(m.addr));
          chk("mem_din", MEM_DIN, m.din);
          chk("mem_valid_cycle", cyc, m.cyc);
        end
      end
      prev_mv = MEM_VALID;
      if (RSP0_VALID || RSP1_VALID) begin
        chkb("rsp_both_valid", RSP0_VALID & RSP1_VALID, 1'b0);
        if (rq.size() == 0) flag("unexpected_rsp_valid");
        else begin
          r = rq.pop_front();
          chkb("rsp_port", RSP1_VALID, r.port);
          chk("rsp_cycle", cyc, r.cyc);
          if (r.port) exp_rsp1 = r.data; else exp_rsp0 = r.data;
        end
      end
      chk("rsp0_data", RSP0_DATA, exp_rsp0);
      chk("rsp1_data", RSP1_DATA, exp_rsp1);
      if (REQ0_READY || REQ1_READY) begin
        chkb("ready_both", REQ0_READY & REQ1_READY, 1'b0);
        chkb("ready_while_busy", BUSY, 1'b0);
        chkb("ready_without_valid", (REQ0_READY & !REQ0_VALID) | (REQ1_READY & !REQ1_VALID), 1'b0);
        p  = REQ1_READY;
        rw = p ? REQ1_RW : REQ0_RW;
        a  = p ? REQ1_ADDR : REQ0_ADDR;
        d  = p ? REQ1_DIN : REQ0_DIN;
        mq.push_back('{rw, a, d, cyc + 1});
        if (rw) begin
          ref_mem[a] = d; ref_seen[a] = 1'b1;
        end else begin
          rq.push_back('{p, ref_seen[a] ? ref_mem[a] : pat(a), cyc + 3});
        end
      end
    end
  endtask

  // Presents a vector at posedge+1, waits for a grant, then drops the winner's VALID.
  task automatic apply(input req_t v, input string name, output int acc, output int waited);
    int n = 0;
    logic g;
    REQ0_VALID = v.v0; REQ0_RW = v.rw0; REQ0_ADDR = v.a0; REQ0_DIN = v.d0;
    REQ1_VALID = v.v1; REQ1_RW = v.rw1; REQ1_ADDR = v.a1; REQ1_DIN = v.d1;
    #1;
    while (!(REQ0_READY || REQ1_READY) && n < 20) begin
      @(posedge CLK); #2; n++;
    end
    acc = cyc;
    waited = n;
    if (n == 20) begin
      flag({name, "_grant_timeout"});
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    end else begin
      g = REQ1_READY;
      chkb({name, "_grant"}, g, v.gnt);
      @(posedge CLK); #1;
      if (g) REQ1_VALID = 1'b0; else REQ0_VALID = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chkb({tag, "_busy"}, BUSY, 1'b0);
    chkb({tag, "_mem_valid"}, MEM_VALID, 1'b0);
    chkb({tag, "_mem_rw"}, MEM_RW, 1'b0);
    chk({tag, "_mem_addr"}, 32'(MEM_ADDR), 32'h0);
    chk({tag, "_mem_din"}, MEM_DIN, 32'h0);
    chkb({tag, "_rsp0_valid"}, RSP0_VALID, 1'b0);
    chkb({tag, "_rsp1_valid"}, RSP1_VALID, 1'b0);
    chk({tag, "_rsp0_data"}, RSP0_DATA, 32'h0);
    chk({tag, "_rsp1_data"}, RSP1_DATA, 32'h0);
    chkb({tag, "_ready0"}, REQ0_READY, 1'b0);
    chkb({tag, "_ready1"}, REQ1_READY, 1'b0);
  endtask

  initial begin
    int acc, waited, prev;
    req_t r;
    RESET_N = 1'b0;
    REQ0_VALID = 1'b0; REQ0_RW = 1'b0; REQ0_ADDR = '0; REQ0_DIN = '0;
    REQ1_VALID = 1'b0; REQ1_RW = 1'b0; REQ1_ADDR = '0; REQ1_DIN = '0;
    fork monitor(); join_none

    //         v0    rw0   a0     d0             v1    rw1   a1     d1             gnt
    vec[0] = '{1'b1, 1'b0, 8'h20, 32'h0,         1'b1, 1'b0, 8'h21, 32'h0,         1'b0};
    vec[1] = '{1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 8'h21, 32'h0,         1'b1};
    vec[2] = '{1'b1, 1'b1, 8'h10, 32'hDEADBEEF,  1'b0, 1'b0, 8'h00, 32'h0,         1'b0};
    vec[3] = '{1'b1, 1'b0, 8'h10, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b0};
    vec[4] = '{1'b1, 1'b1, 8'h30, 32'h11111111,  1'b1, 1'b1, 8'h31, 32'h22222222,  1'b1};
    vec[5] = '{1'b1, 1'b1, 8'h30, 32'h11111111,  1'b1, 1'b0, 8'h10, 32'h0,         1'b0};
    vec[6] = '{1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 8'h10, 32'h0,         1'b1};
    vec[7] = '{1'b1, 1'b0, 8'h30, 32'h0,         1'b1, 1'b0, 8'h31, 32'h0,         1'b0};
    vec[8] = '{1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 8'h31, 32'h0,         1'b1};

    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RESET_N = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply(vec[i], $sformatf("vec%0d", i), acc, waited);
      if (i == 0) chk("first_edge_accept_wait", waited, 0);
      if (i == 3) begin
        repeat (2) @(posedge CLK);
        #1;
        chkb("rd_after_wr_rsp0_valid", RSP0_VALID, 1'b1);
        chk("rd_after_wr_rsp0_data", RSP0_DATA, 32'hDEADBEEF);
      end
    end

    // Both ports hold VALID: grants must alternate 0,1,0,1,0,1.
    for (int k = 0; k < 6; k++) begin
      r = '{1'b1, 1'b1, 8'h40 + 8'(k / 2), 32'hA0000000 + 32'(k / 2),
            1'b1, 1'b0, 8'h40 + 8'(k / 2), 32'h0, k[0]};
      apply(r, $sformatf("alt%0d", k), acc, waited);
    end

    // Port 1 back-to-back writes: one acceptance every second cycle.
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      r = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h50 + 8'(k), 32'h5000_0000 + 32'(k), 1'b1};
      apply(r, $sformatf("p1wr%0d", k), acc, waited);
      if (k > 0) chk("p1wr_spacing", acc - prev, 2);
      prev = acc;
    end

    // Port 0 raises VALID while a port-1 read is in flight.
    r = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h52, 32'h0, 1'b1};
    apply(r, "busy_rd1", acc, waited);
    chkb("busy_in_issue", BUSY, 1'b1);
    prev = acc;
    r = '{1'b1, 1'b0, 8'h41, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0};
    apply(r, "busy_rd0", acc, waited);
    chk("accept_after_read_latency", acc - prev, 3);

    // Reset while a port-1 read sits in CAPTURE.
    repeat (4) @(posedge CLK);
    #1;
    r = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h21, 32'h0, 1'b1};
    apply(r, "abort_rd1", acc, waited);
    @(posedge CLK); #1;
    chkb("busy_in_capture", BUSY, 1'b1);
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chkb("no_rsp1_after_reset", RSP1_VALID, 1'b0);
      chkb("no_mem_valid_after_reset", MEM_VALID, 1'b0);
      @(posedge CLK); #1;
    end
    check_reset_outputs("post_abort");

    repeat (4) @(posedge CLK);
    #1;
    chk("sb_mem_drained", mq.size(), 0);
    chk("sb_rsp_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: MEM_ARBITER

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the memory address width (memory depth 2**WIDTH words of 32 bits).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports REQ0_VALID / REQ1_VALID  input  1  requestor n has a pending access.
REQ-005 SHALL have ports REQ0_RW / REQ1_RW  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports REQ0_ADDR / REQ1_ADDR  input  WIDTH  word address.
REQ-007 SHALL have ports REQ0_DIN / REQ1_DIN  input  32  write data.
REQ-008 SHALL have ports REQ0_READY / REQ1_READY  output  1  request accepted this cycle (combinational).
REQ-009 SHALL have ports RSP0_VALID / RSP1_VALID  output  1  one-cycle read-data pulse.
REQ-010 SHALL have ports RSP0_DATA / RSP1_DATA  output  32  read data, held until next response to that port.
REQ-011 SHALL have port MEM_VALID  output  1  memory access strobe.
REQ-012 SHALL have port MEM_RW  output  1  memory direction, 1 = write.
REQ-013 SHALL have port MEM_ADDR  output  WIDTH  memory address.
REQ-014 SHALL have port MEM_DIN  output  32  memory write data.
REQ-015 SHALL have port MEM_DOUT  input  32  memory read data, registered, valid the cycle after a read strobe.
REQ-016 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE.
REQ-018 In IDLE, if any REQn_VALID is high, SHALL assert exactly one REQn_READY (the grant) in the same cycle, latch RW/ADDR/DIN and the granted index, and go to ISSUE.
REQ-019 Grant: only one valid -> that port; both valid -> port not granted last; after reset port 0 wins the first tie.
REQ-020 The last-grant pointer SHALL update only on an accepted request.
REQ-021 REQn_READY SHALL be 0 in ISSUE and CAPTURE; requestors hold REQn_* stable until READY.
REQ-022 In ISSUE, MEM_VALID = 1 for exactly one cycle with latched MEM_RW/MEM_ADDR/MEM_DIN; write -> IDLE, read -> CAPTURE.
REQ-023 In CAPTURE, SHALL register MEM_DOUT into RSPn_DATA of the granted port, pulse RSPn_VALID for one cycle starting the next cycle, and go to IDLE.
REQ-024 Writes SHALL produce no RSPn_VALID pulse.
REQ-025 Latency: READY in cycle 0, MEM_VALID in cycle 1, RSPn_VALID in cycle 3; new request acceptable in cycle 2 (after write) or cycle 3 (after read).
REQ-026 RSPn_VALID of a completed read SHALL coexist with a new acceptance in the same cycle; no response-side backpressure.
REQ-027 MEM_VALID SHALL be 0 in IDLE and CAPTURE; MEM_RW/MEM_ADDR/MEM_DIN hold last latched values.
REQ-028 RSPn_DATA of the non-granted port SHALL be unchanged by any transaction.
REQ-029 REQn_VALID deasserted without READY SHALL be a legal withdrawal with no side effect.

Reset
REQ-030 On RESET_N low: state IDLE, MEM_VALID 0, MEM_RW 0, MEM_ADDR 0, MEM_DIN 0, RSP0/1_VALID 0, RSP0/1_DATA 0, last-grant pointer = port 1 (so port 0 wins first tie), BUSY 0.
REQ-031 Reset asserted mid-transaction SHALL abandon it immediately: no MEM_VALID, no RSP pulse afterward.
REQ-032 After RESET_N rises, first acceptance SHALL be possible on the first rising edge.

Verification
REQ-033 Port0 write ADDR 0x10 DIN 0xDEADBEEF, then port0 read 0x10 -> MEM_VALID=1 MEM_RW=1 one cycle; read yields RSP0_VALID pulse 3 cycles after READY, RSP0_DATA=0xDEADBEEF.
REQ-034 Both ports request reads in the same cycle after reset -> port0 granted first, port1 next; each RSPn_DATA gets its own word, other port's RSP data unchanged.
REQ-035 Both ports hold VALID continuously for 6 requests -> grants alternate 0,1,0,1,0,1; no port starved.
REQ-036 Back-to-back writes from port1 only -> READY every 2nd cycle, MEM_VALID every 2nd cycle, no RSP1_VALID pulse.
REQ-037 RESET_N pulled low in CAPTURE of a port1 read -> RSP1_VALID never pulses, BUSY=0, all outputs at reset values.
REQ-038 REQ0_VALID raised during BUSY -> REQ0_READY stays 0 until IDLE, then accepted; MEM_VALID never asserted two cycles in a row.
